// File: rtl/rv16_mult_pkg.sv
// Shared types and default sizing for the rv16 sequential multiplier.
package rv16_mult_pkg;

    localparam int unsigned DefXlen   = 16;
    localparam int unsigned DefSlice  = 4;
    localparam int unsigned NumDigits = DefXlen / DefSlice;
    localparam int unsigned KWidth    = $clog2(NumDigits * NumDigits);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/rv16_mult_slice.sv
// Combinational Width x Width -> 2*Width unsigned array multiplier.
// Each row is a ripple of adders that folds one shifted partial-product row into the running sum.
module rv16_mult_slice #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0]   a_i,
    input  logic [Width-1:0]   b_i,
    output logic [2*Width-1:0] p_o
);

    for (genvar r = 0; r < Width; r++) begin : g_row
        logic [2*Width-1:0] prev;
        logic [2*Width-1:0] sum;

        if (r == 0) begin : g_first
            assign prev = '0;
        end else begin : g_next
            assign prev = g_row[r-1].sum;
        end

        for (genvar c = 0; c < Width; c++) begin : g_col
            logic pbit;
            logic ci;
            logic co;

            assign pbit = a_i[c] & b_i[r];
            if (c == 0) begin : g_ha
                assign ci = 1'b0;
            end else begin : g_fa
                assign ci = g_col[c-1].co;
            end
            assign sum[r+c] = prev[r+c] ^ pbit ^ ci;
            assign co       = (prev[r+c] & pbit) | (ci & (prev[r+c] ^ pbit));
        end

        // Top column is a half adder; its carry is provably zero since the product fits.
        assign sum[r+Width] = prev[r+Width] ^ g_col[Width-1].co;

        for (genvar t = 0; t < 2 * Width; t++) begin : g_pass
            if (t < r || t > r + Width) begin : g_keep
                assign sum[t] = prev[t];
            end
        end
    end

    assign p_o = g_row[Width-1].sum;

endmodule

// File: rtl/rv16_mult_seq.sv
// Sequential XLEN x XLEN multiplier: one SLICE x SLICE partial product per cycle into a
// 2*XLEN accumulator, result returned through a valid/ready handshake.
module rv16_mult_seq
    import rv16_mult_pkg::*;
#(
    parameter int unsigned XLEN  = DefXlen,
    parameter int unsigned SLICE = DefSlice
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*XLEN-1:0] out_prod,
    output logic              busy
);

    localparam int unsigned N     = XLEN / SLICE;
    localparam int unsigned NumPp = N * N;
    localparam int unsigned KW    = $clog2(NumPp);
    localparam int unsigned PW    = 2 * XLEN;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     prod_q, prod_d;

    logic [KW-1:0]     idx_i, idx_j;
    logic [SLICE-1:0]  dig_a, dig_b;
    logic [2*SLICE-1:0] pp;
    logic [PW-1:0]     pp_ext;
    logic [PW-1:0]     acc_sum;
    logic              last_k;

    // Two's-complement negate when neg is set; also yields |v| from a sign-extended operand.
    function automatic logic [PW-1:0] cond_neg(input logic [PW-1:0] v, input logic neg);
        return neg ? (~v + PW'(1)) : v;
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        logic [PW-1:0] wide;
        wide = cond_neg({{XLEN{sgn & v[XLEN-1]}}, v}, sgn & v[XLEN-1]);
        return wide[XLEN-1:0];
    endfunction

    rv16_mult_slice #(
        .Width(SLICE)
    ) u_slice (
        .a_i(dig_a),
        .b_i(dig_b),
        .p_o(pp)
    );

    always_comb begin
        idx_i   = k_q / KW'(N);
        idx_j   = k_q % KW'(N);
        dig_a   = SLICE'(mag_a_q >> (idx_i * SLICE));
        dig_b   = SLICE'(mag_b_q >> (idx_j * SLICE));
        pp_ext  = {{(PW - 2 * SLICE){1'b0}}, pp};
        acc_sum = acc_q + (pp_ext << (SLICE * (idx_i + idx_j)));
        last_k  = (k_q == KW'(NumPp - 1));
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        prod_d  = prod_q;

        if (flush) begin
            state_d = StIdle;
            k_d     = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mag_a_d = magnitude(in_a, in_signed);
                        mag_b_d = magnitude(in_b, in_signed);
                        neg_d   = in_signed & (in_a[XLEN-1] ^ in_b[XLEN-1]);
                        acc_d   = '0;
                        state_d = StCalc;
                        // A zero operand skips straight to the final step: one pass, pp = 0.
                        k_d     = (in_a == '0 || in_b == '0) ? KW'(NumPp - 1) : '0;
                    end
                end
                StCalc: begin
                    acc_d = acc_sum;
                    k_d   = k_q + KW'(1);
                    if (last_k) begin
                        prod_d  = cond_neg(acc_sum, neg_q);
                        k_d     = '0;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign out_prod  = prod_q;

endmodule

// File: tb/tb_rv16_mult_seq.sv
// Directed self-checking bench for rv16_mult_seq with hand-computed products and latencies.
module tb_rv16_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_prod;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv16_mult_seq u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_signed(in_signed),
        .in_a     (in_a),
        .in_b     (in_b),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_prod (out_prod),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait (bounded) for out_valid, check latency and product.
    task automatic do_op(input string tag, input logic sgn, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] want, input int want_lat);
        int lat;
        check({tag, " rdy"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_signed = sgn;
        in_a      = a;
        in_b      = b;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " lat"}, 64'(lat), 64'(want_lat));
        check({tag, " prod"}, 64'(out_prod), 64'(want));
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst vld", 64'(out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst prod", 64'(out_prod), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst rdy", 64'(in_ready), 64'd1);

        do_op("u3x5", 1'b0, 16'h0003, 16'h0005, 32'h0000_000F, 16);
        tick();
        check("u3x5 vld drop", 64'(out_valid), 64'd0);
        check("u3x5 rdy back", 64'(in_ready), 64'd1);

        do_op("uffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16);
        tick();
        do_op("s-1x-1", 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 16);
        tick();
        do_op("s8000x7fff", 1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000, 16);
        tick();
        do_op("s8000x8000", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 16);
        tick();

        // Zero early-out, then stall the consumer while in_valid pulses.
        out_ready = 1'b0;
        do_op("zero", 1'b0, 16'h0000, 16'h1234, 32'h0, 1);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            in_a     = 16'h0003;
            in_b     = 16'h0005;
            tick();
            check("hold vld", 64'(out_valid), 64'd1);
            check("hold prod", 64'(out_prod), 64'd0);
            check("hold rdy", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("hold release", 64'(out_valid), 64'd0);
        check("hold rdy back", 64'(in_ready), 64'd1);

        // flush beats a simultaneous accept.
        in_valid = 1'b1;
        flush    = 1'b1;
        in_a     = 16'h0002;
        in_b     = 16'h0002;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush acc busy", 64'(busy), 64'd0);

        // flush at k=7.
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'h5678;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("pre-flush busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush rdy", 64'(in_ready), 64'd1);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) seen++;
            tick();
        end
        check("flush no vld", 64'(seen), 64'd0);
        do_op("u7x9", 1'b0, 16'h0007, 16'h0009, 32'h0000_003F, 16);
        tick();

        // Asynchronous reset mid-CALC.
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst vld", 64'(out_valid), 64'd0);
        check("arst busy", 64'(busy), 64'd0);
        check("arst prod", 64'(out_prod), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst rdy", 64'(in_ready), 64'd1);
        do_op("u1234x2", 1'b0, 16'h1234, 16'h0002, 32'h0000_2468, 16);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
